// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and data access (DM).
// Optional round-robin tie-breaking is enabled by defining ARB_RR_EN; the default build uses fixed DM-over-IF priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifDone,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              dmReq,
  input  logic              dmWe,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWdata,
  output logic              dmDone,
  output logic [DATA_W-1:0] dmRdata,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady,
  output logic              ifStall,
  output logic              dmStall,
  output logic              busErr
);

  typedef enum logic [1:0] {IDLE, SERV_IF, SERV_DM} state_t;

  state_t     state, stateNx;
  logic [7:0] waitCnt;
  logic       weLat;
  logic       lastGrant;  // 1 = DM was granted last, 0 = IF
  logic       grantDm, grantIf, timeout;

  // A requester whose done pulse is high this cycle is not eligible for grant.
  assign ifStall = ifReq & ~ifDone;
  assign dmStall = dmReq & ~dmDone;

  assign memEn   = (state != IDLE);
  assign memWe   = (state == SERV_DM) & weLat;
  assign timeout = (waitCnt == 8'(MAX_WAIT - 1));

`ifdef ARB_RR_EN
  always_comb begin
    grantDm = dmStall & (~ifStall | ~lastGrant);
    grantIf = ifStall & ~grantDm;
  end
`else
  logic unused_lastgrant;
  assign unused_lastgrant = lastGrant;

  always_comb begin
    grantDm = dmStall;
    grantIf = ifStall & ~grantDm;
  end
`endif

  always_comb begin
    stateNx = state;
    case (state)
      IDLE: begin
        if (grantDm)      stateNx = SERV_DM;
        else if (grantIf) stateNx = SERV_IF;
      end
      SERV_IF, SERV_DM: begin
        if (memReady || timeout) stateNx = IDLE;
      end
      default: stateNx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      memAddr   <= '0;
      memWdata  <= '0;
      weLat     <= 1'b0;
      ifRdata   <= '0;
      dmRdata   <= '0;
      ifDone    <= 1'b0;
      dmDone    <= 1'b0;
      busErr    <= 1'b0;
      waitCnt   <= '0;
      lastGrant <= 1'b0;
    end else begin
      state  <= stateNx;
      ifDone <= 1'b0;
      dmDone <= 1'b0;
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (grantDm) begin
            memAddr   <= dmAddr;
            memWdata  <= dmWdata;
            weLat     <= dmWe;
            lastGrant <= 1'b1;
          end else if (grantIf) begin
            memAddr   <= ifAddr;
            weLat     <= 1'b0;
            lastGrant <= 1'b0;
          end
        end
        SERV_IF: begin
          if (memReady) begin
            ifRdata <= memRdata;
            ifDone  <= 1'b1;
          end else if (timeout) begin
            ifRdata <= '1;
            ifDone  <= 1'b1;
            busErr  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        SERV_DM: begin
          // memReady takes precedence over a simultaneous watchdog expiry.
          if (memReady) begin
            if (!weLat) dmRdata <= memRdata;
            dmDone <= 1'b1;
          end else if (timeout) begin
            if (!weLat) dmRdata <= '1;
            dmDone <= 1'b1;
            busErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
